// File: rtl/easy_axi_top.sv
// EasyAXI demo subsystem: an AXI4 read master and a pattern-memory slave wired back to back.
// Optional feature: define EASYAXI_OUTSTANDING_EN for up to 4 outstanding reads (4-deep slave AR FIFO).
module easy_axi_top #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 4,
  parameter int BURST_LEN = 3,
  parameter int TXN_NUM   = 4,
  parameter int BASE_ADDR = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic done
);

  // state  | meaning
  // S_IDLE | counters cleared, waiting for enable
  // S_AR   | issuing read address (outstanding build: issuing while beats return)
  // S_R    | receiving / draining read beats
  // S_DONE | all bursts completed, done held until enable drops

  localparam int BYTES  = DATA_W / 8;
  localparam int SIZE   = $clog2(BYTES);
  localparam int STRIDE = (BURST_LEN + 1) * BYTES;
  localparam int CNT_W  = ($clog2(TXN_NUM + 1) > 3) ? $clog2(TXN_NUM + 1) : 3;
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
  localparam logic [CNT_W-1:0] N_TXN    = CNT_W'(TXN_NUM);
  localparam logic [CNT_W-1:0] LAST_TXN = CNT_W'(TXN_NUM - 1);
  localparam logic [7:0]       LEN      = 8'(BURST_LEN);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_t;

  logic              arvalid, arready;
  logic [ADDR_W-1:0] araddr;
  logic [ID_W-1:0]   arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              rvalid, rready;
  logic [DATA_W-1:0] rdata;
  logic [ID_W-1:0]   rid;
  logic [1:0]        rresp;
  logic              rlast;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  ar_cnt, rd_cnt;
  logic [7:0]        beat_cnt;
  logic              err;
  logic              ar_hs, r_hs, last_hs, beat_bad;

  function automatic logic [ADDR_W-1:0] txn_addr(input logic [CNT_W-1:0] n);
    return ADDR_W'(BASE_ADDR + int'(n) * STRIDE);
  endfunction

  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
    return DATA_W'(a) ^ DATA_W'(32'hA5A5_0000);
  endfunction

  assign ar_hs   = arvalid & arready;
  assign r_hs    = rvalid & rready;
  assign last_hs = r_hs & rlast;

  assign araddr  = txn_addr(ar_cnt);
  assign arid    = ID_W'(ar_cnt);
  assign arlen   = LEN;
  assign arsize  = 3'(SIZE);
  assign arburst = 2'b01;

  // ---------------- master FSM ----------------
  always_ff @(posedge clk) begin
    if (rst_n) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (enable) state_nx = S_AR;
`ifdef EASYAXI_OUTSTANDING_EN
      S_AR: begin
        if (ar_hs && ar_cnt == LAST_TXN)        state_nx = S_R;
        else if (!enable && (!arvalid || ar_hs)) state_nx = S_R;
      end
      S_R: begin
        if (last_hs) begin
          if (rd_cnt == LAST_TXN)               state_nx = S_DONE;
          else if (ar_cnt == rd_cnt + ONE_C)    state_nx = S_IDLE;
        end else if (ar_cnt == rd_cnt)          state_nx = S_IDLE;
      end
`else
      S_AR: if (ar_hs) state_nx = S_R;
      S_R: begin
        if (last_hs) begin
          if (rd_cnt == LAST_TXN) state_nx = S_DONE;
          else if (enable)        state_nx = S_AR;
          else                    state_nx = S_IDLE;
        end
      end
`endif
      S_DONE: if (!enable) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

`ifdef EASYAXI_OUTSTANDING_EN
  logic [CNT_W-1:0] outst;
  assign outst = ar_cnt - rd_cnt;
`endif

  always_comb begin
    done = (state == S_DONE);
`ifdef EASYAXI_OUTSTANDING_EN
    // Inputs to arvalid only move toward "still valid" until the handshake, so VALID stays stable.
    arvalid = (state == S_AR) && (ar_cnt < N_TXN) && (outst < CNT_W'(4));
    rready  = (state == S_AR) || (state == S_R);
`else
    arvalid = (state == S_AR);
    rready  = (state == S_R);
`endif
  end

  // Beats come back in issue order, so the expected beat follows rd_cnt/beat_cnt.
  assign beat_bad = (rid != ID_W'(rd_cnt)) || (rresp != 2'b00) || (rlast != (beat_cnt == LEN)) ||
                    (rdata != pattern(txn_addr(rd_cnt) + ADDR_W'(int'(beat_cnt) * BYTES)));

  always_ff @(posedge clk) begin
    if (rst_n) begin
      ar_cnt   <= '0;
      rd_cnt   <= '0;
      beat_cnt <= '0;
      err      <= 1'b0;
    end else if (state == S_IDLE) begin
      ar_cnt   <= '0;
      rd_cnt   <= '0;
      beat_cnt <= '0;
    end else begin
      if (ar_hs) ar_cnt <= ar_cnt + ONE_C;
      if (r_hs) begin
        err <= err | beat_bad;
        if (rlast) begin
          beat_cnt <= '0;
          rd_cnt   <= rd_cnt + ONE_C;
        end else begin
          beat_cnt <= beat_cnt + 8'd1;
        end
      end
    end
  end

  // ---------------- slave ----------------
  logic              s_busy, s_incr;
  logic [ADDR_W-1:0] s_addr;
  logic [ID_W-1:0]   s_id;
  logic [7:0]        s_len, s_cnt;
  logic [2:0]        s_size;

  assign rvalid = s_busy;
  assign rdata  = pattern(s_addr);
  assign rid    = s_id;
  assign rresp  = 2'b00;
  assign rlast  = (s_cnt == s_len);

`ifdef EASYAXI_OUTSTANDING_EN
  localparam int ENT_W = ADDR_W + ID_W + 8 + 3 + 1;
  logic [ENT_W-1:0] fifo [4];
  logic [1:0]       wp, rp;
  logic [2:0]       fcnt;
  logic             load;

  assign arready = (fcnt != 3'd4);
  // Pop on the final beat too, so consecutive bursts stream without a bubble.
  assign load    = (fcnt != 3'd0) && (!s_busy || last_hs);

  always_ff @(posedge clk) begin
    if (ar_hs) fifo[wp] <= {araddr, arid, arlen, arsize, (arburst == 2'b01)};
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      wp <= '0; rp <= '0; fcnt <= '0;
      s_busy <= 1'b0; s_incr <= 1'b0; s_addr <= '0; s_id <= '0;
      s_len <= '0; s_cnt <= '0; s_size <= '0;
    end else begin
      if (ar_hs) wp <= wp + 2'd1;
      if (load)  rp <= rp + 2'd1;
      fcnt <= fcnt + {2'b00, ar_hs} - {2'b00, load};
      if (load) begin
        s_busy <= 1'b1;
        {s_addr, s_id, s_len, s_size, s_incr} <= fifo[rp];
        s_cnt  <= '0;
      end else if (r_hs) begin
        if (rlast) begin
          s_busy <= 1'b0;
        end else begin
          s_addr <= s_addr + (s_incr ? (ADDR_W'(1) << s_size) : '0);
          s_cnt  <= s_cnt + 8'd1;
        end
      end
    end
  end
`else
  assign arready = !s_busy;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      s_busy <= 1'b0; s_incr <= 1'b0; s_addr <= '0; s_id <= '0;
      s_len <= '0; s_cnt <= '0; s_size <= '0;
    end else if (ar_hs) begin
      s_busy <= 1'b1;
      s_addr <= araddr;
      s_id   <= arid;
      s_len  <= arlen;
      s_size <= arsize;
      s_incr <= (arburst == 2'b01);
      s_cnt  <= '0;
    end else if (r_hs) begin
      if (rlast) begin
        s_busy <= 1'b0;
      end else begin
        s_addr <= s_addr + (s_incr ? (ADDR_W'(1) << s_size) : '0);
        s_cnt  <= s_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_easy_axi_top.sv
// Scoreboard bench for easy_axi_top: two instances (BASE_ADDR 0 and 0xFFF0) driven in lockstep,
// internal AXI traffic observed hierarchically and compared against queued expectations.
module tb_easy_axi_top;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  logic done_a, done_b;

  always #5 clk = ~clk;

  easy_axi_top #(.BASE_ADDR(0))     dut_a (.clk(clk), .rst_n(rst_n), .enable(enable), .done(done_a));
  easy_axi_top #(.BASE_ADDR(65520)) dut_b (.clk(clk), .rst_n(rst_n), .enable(enable), .done(done_b));

  typedef struct packed { logic [15:0] addr; logic [3:0] id; } ar_exp_t;
  typedef struct packed { logic [31:0] data; logic [3:0] id; logic last; } r_exp_t;

  ar_exp_t     exp_ar[2][$];
  r_exp_t      exp_r[2][$];
  int          errors = 0;
  int          checks = 0;
  int          ar_hs_cnt[2] = '{0, 0};
  int          first_rlast_ars[2] = '{-1, -1};
  logic [31:0] first_rdata[2];
  bit          got_first[2] = '{0, 0};

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, expv);
    end
  endtask

  task automatic push_run(input int ntxn);
    logic [15:0] base, a, ba;
    for (int k = 0; k < 2; k++) begin
      base = (k == 0) ? 16'h0000 : 16'hFFF0;
      for (int i = 0; i < ntxn; i++) begin
        a = base + 16'(i * 16);
        exp_ar[k].push_back('{addr: a, id: 4'(i)});
        for (int j = 0; j < 4; j++) begin
          ba = a + 16'(j * 4);
          exp_r[k].push_back('{data: {16'h0000, ba} ^ 32'hA5A5_0000, id: 4'(i), last: (j == 3)});
        end
      end
    end
  endtask

  task automatic flush();
    for (int k = 0; k < 2; k++) begin
      exp_ar[k].delete();
      exp_r[k].delete();
    end
  endtask

  task automatic mon(input int k,
                     input logic arv, input logic arr, input logic [15:0] ara, input logic [3:0] ari,
                     input logic [7:0] arl, input logic [2:0] ars, input logic [1:0] arb,
                     input logic rv, input logic rr, input logic [31:0] rd, input logic [3:0] ri,
                     input logic [1:0] rp, input logic rl);
    ar_exp_t ea;
    r_exp_t  er;
    if (arv && arr) begin
      ar_hs_cnt[k]++;
      if (exp_ar[k].size() == 0) begin
        checks++; errors++;
        $display("FAIL ar_unexpected[%0d]: got addr 0x%0h id %0d, expected no AR", k, ara, ari);
      end else begin
        ea = exp_ar[k].pop_front();
        chk($sformatf("araddr[%0d]", k), 64'(ara), 64'(ea.addr));
        chk($sformatf("arid[%0d]", k),   64'(ari), 64'(ea.id));
        chk($sformatf("arlen[%0d]", k),  64'(arl), 64'(3));
        chk($sformatf("arsize[%0d]", k), 64'(ars), 64'(2));
        chk($sformatf("arburst[%0d]", k), 64'(arb), 64'(1));
      end
    end
    if (rv && rr) begin
      if (!got_first[k]) begin
        got_first[k]   = 1'b1;
        first_rdata[k] = rd;
      end
      if (rl && first_rlast_ars[k] < 0) first_rlast_ars[k] = ar_hs_cnt[k];
      if (exp_r[k].size() == 0) begin
        checks++; errors++;
        $display("FAIL r_unexpected[%0d]: got data 0x%0h id %0d, expected no beat", k, rd, ri);
      end else begin
        er = exp_r[k].pop_front();
        chk($sformatf("rdata[%0d]", k), 64'(rd), 64'(er.data));
        chk($sformatf("rid[%0d]", k),   64'(ri), 64'(er.id));
        chk($sformatf("rresp[%0d]", k), 64'(rp), 64'(0));
        chk($sformatf("rlast[%0d]", k), 64'(rl), 64'(er.last));
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, dut_a.arvalid, dut_a.arready, dut_a.araddr, dut_a.arid, dut_a.arlen, dut_a.arsize,
        dut_a.arburst, dut_a.rvalid, dut_a.rready, dut_a.rdata, dut_a.rid, dut_a.rresp, dut_a.rlast);
    mon(1, dut_b.arvalid, dut_b.arready, dut_b.araddr, dut_b.arid, dut_b.arlen, dut_b.arsize,
        dut_b.arburst, dut_b.rvalid, dut_b.rready, dut_b.rdata, dut_b.rid, dut_b.rresp, dut_b.rlast);
  end

  task automatic wait_done(input int bound, output int n);
    n = 0;
    while (!done_a && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("done_a_reached", 64'(done_a), 64'(1));
    chk("done_b_reached", 64'(done_b), 64'(1));
  endtask

  task automatic check_drained(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_ar_left[%0d]", tag, k), 64'(exp_ar[k].size()), 64'(0));
      chk($sformatf("%s_r_left[%0d]", tag, k),  64'(exp_r[k].size()), 64'(0));
    end
    chk($sformatf("%s_err_a", tag), 64'(dut_a.err), 64'(0));
    chk($sformatf("%s_err_b", tag), 64'(dut_b.err), 64'(0));
  endtask

  initial begin
    int n;
    int cnt;
    rst_n  = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    chk("rst_done", 64'(done_a), 64'(0));
    chk("rst_arvalid", 64'(dut_a.arvalid), 64'(0));
    chk("rst_rvalid", 64'(dut_a.rvalid), 64'(0));
    chk("rst_err", 64'(dut_a.err), 64'(0));

    // full run
    push_run(4);
    enable = 1'b1;
    wait_done(60, n);
`ifdef EASYAXI_OUTSTANDING_EN
    chk("t1_latency", 64'(n), 64'(19));
    chk("t1_ars_before_rlast", 64'(first_rlast_ars[0]), 64'(4));
`else
    chk("t1_latency", 64'(n), 64'(21));
    chk("t1_ars_before_rlast", 64'(first_rlast_ars[0]), 64'(1));
`endif
    chk("t1_first_rdata_a", 64'(first_rdata[0]), 64'(32'hA5A5_0000));
    chk("t1_first_rdata_b", 64'(first_rdata[1]), 64'(32'hA5A5_FFF0));
    check_drained("t1");

    // done holds while enabled, then clears and stays idle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_done_held", 64'(done_a), 64'(1));
    end
    enable = 1'b0;
    @(negedge clk);
    chk("t2_done_clear_a", 64'(done_a), 64'(0));
    chk("t2_done_clear_b", 64'(done_b), 64'(0));
    cnt = 0;
    repeat (150) begin
      @(negedge clk);
      if (dut_a.arvalid || dut_b.arvalid) cnt++;
    end
    chk("t2_idle_arvalid", 64'(cnt), 64'(0));

`ifndef EASYAXI_OUTSTANDING_EN
    // abort after the second AR handshake: txn 1 drains, nothing more issued
    push_run(2);
    enable = 1'b1;
    n = 0;
    while (!(dut_a.arvalid && dut_a.arready && dut_a.arid == 4'd1) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("t3_second_ar_seen", 64'(n < 40), 64'(1));
    @(negedge clk);
    enable = 1'b0;
    repeat (30) @(negedge clk);
    chk("t3_done_low", 64'(done_a), 64'(0));
    check_drained("t3_abort");
    push_run(4);
    enable = 1'b1;
    wait_done(60, n);
    check_drained("t3_restart");
    enable = 1'b0;
    @(negedge clk);
`endif

    // reset in the middle of txn 1
    push_run(4);
    enable = 1'b1;
    n = 0;
    while (!(dut_a.rvalid && dut_a.rid == 4'd1) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("t4_midburst_seen", 64'(n < 60), 64'(1));
    rst_n  = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    chk("t4_arvalid", 64'(dut_a.arvalid), 64'(0));
    chk("t4_rvalid", 64'(dut_a.rvalid), 64'(0));
    chk("t4_done", 64'(done_a), 64'(0));
    chk("t4_rvalid_b", 64'(dut_b.rvalid), 64'(0));
    flush();
    rst_n = 1'b0;
    push_run(4);
    enable = 1'b1;
    wait_done(60, n);
    check_drained("t4_rerun");
    enable = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at 200000, expected finish");
    $fatal(1, "timeout");
  end

endmodule
